div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequencer between the EX-stage ALU and the multi-cycle SRT divider core.
//  - Accepts one div/mod request at a time over a valid/ready handshake.
//  - Resolves special cases locally: divide-by-zero and signed overflow.
//  - Serves repeated operand pairs from a small result cache.
//  - Otherwise starts the core and waits for its result.
//  - Returns the quotient and remainder together, and supports a pipeline flush.
// PARAMETERS
//  CACHE_DEPTH  8   number of result-cache entries, power of 2, >=2
//  DATA_W       32  operand/result width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  flush        in   1       abort the current operation (branch mispredict/exception)
//  req_valid    in   1       request valid
//  req_ready    out  1       controller can accept a request
//  req_sign     in   1       1 = signed (div/mod), 0 = unsigned (divu/modu)
//  req_op1      in   DATA_W  dividend
//  req_op2      in   DATA_W  divisor
//  resp_valid   out  1       result valid; held until accepted
//  resp_ready   in   1       consumer accepts the result
//  resp_quo     out  DATA_W  quotient
//  resp_rem     out  DATA_W  remainder
//  core_start   out  1       one-cycle start pulse to the divider core
//  core_abort   out  1       one-cycle abort pulse to the divider core
//  core_sign    out  1       sign mode, stable for the whole core run
//  core_op1     out  DATA_W  dividend, stable for the whole core run
//  core_op2     out  DATA_W  divisor, stable for the whole core run
//  core_done    in   1       one-cycle pulse: core results are valid this cycle
//  core_quo     in   DATA_W  quotient from the core
//  core_rem     in   DATA_W  remainder from the core
// BEHAVIOUR
//  Reset: state=IDLE.
//   - All outputs 0, except req_ready=1.
//   - All cache valid bits 0; replacement pointer 0.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - req_ready = ~flush.
//   - An accept (req_valid & req_ready) latches sign/op1/op2.
//   - The result is decided from the latched operands, in this priority order:
//     1. op2==0: quo=all-ones, rem=op1; go to DONE. No core start, no cache write.
//     2. sign & op1==0x8000_0000 & op2==all-ones: quo=0x8000_0000, rem=0; go to DONE.
//        No core start, no cache write.
//     3. Cache hit on the key {sign,op1,op2}: quo/rem from the entry; go to DONE.
//        If several entries match, the lowest index wins.
//     4. Miss: pulse core_start in the cycle after the accept; go to BUSY.
//   - Cases 1-3 give resp_valid in the cycle after the accept (latency 1).
//  BUSY:
//   - req_ready=0; core_op*/core_sign hold the latched values.
//   - On core_done: capture quo/rem; write the cache entry at the pointer;
//     pointer+1, wrapping CACHE_DEPTH-1 -> 0; go to DONE.
//   - Miss latency = core latency + 1 cycle.
//  DONE:
//   - resp_valid=1; resp_quo/resp_rem stable; req_ready=0.
//   - resp_valid & resp_ready -> IDLE.
//   - A new request can be accepted in the cycle after the response handshake.
//  flush (takes priority over every other event):
//   - From any state, the next state is IDLE.
//   - resp_valid drops the next cycle.
//   - In BUSY: core_abort pulses for 1 cycle and there is no cache write.
//   - flush together with core_done: flush wins; the result and the cache write are discarded.
//   - flush together with req_valid in IDLE: the request is not accepted.
//  Cache:
//   - Writes happen only on core completion.
//   - Lookup is combinational on the latched operands.
//   - Only misses are written, so the cache holds no duplicate keys.
//  Reset mid-operation: returns to the reset values immediately (asynchronous); no core_abort is issued.
//  core_start and core_done in the same cycle cannot occur; the core guarantees done >= 1 cycle after start.
// STRUCTURE
//  Shared package/defines: FSM state encoding (2 bits); DIV_ZERO_QUO constant;
//   signed-overflow operand constants.
//  Sub-module div_result_cache:
//   - Ports: clk, rst, key in, hit, quo, rem, wr_en, wr data.
//   - Owns the valid bits, the key/quo/rem arrays and the round-robin pointer.
//  Top level: FSM, special-case detection, handshake, core interface registers.
// TESTING
//  1. Unsigned miss, 100/7: core run -> resp quo=14, rem=2; the entry is cached;
//     resp_valid holds while resp_ready=0.
//  2. Repeat unsigned 100/7: no core_start; resp_valid 1 cycle after accept; quo=14, rem=2.
//  3. Signed 7/0: quo=0xFFFF_FFFF, rem=7, latency 1, no core_start;
//     signed 0x8000_0000/-1 -> quo=0x8000_0000, rem=0.
//  4. Signed -7/2 miss: quo=0xFFFF_FFFD, rem=0xFFFF_FFFF;
//     the same operands unsigned are a miss (sign is part of the key).
//  5. flush 3 cycles into BUSY: core_abort pulses once, IDLE next cycle,
//     no resp_valid, no cache write (same request misses again);
//     flush + core_done in the same cycle -> result discarded.
//  6. 9 distinct misses with CACHE_DEPTH=8: the first entry is evicted (pointer wraps);
//     re-issuing the 1st pair misses, the 2nd pair hits.
//     Also: async rst asserted mid-BUSY -> outputs reset immediately, req_ready=1.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: FSM encoding and
// special-case constants (sized at 64 bits, sliced down to DATA_W by users).
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] DIV_ZERO_QUO = '1;

  // Most negative value of a w-bit two's complement number (signed-overflow dividend).
  function automatic logic [63:0] ovf_dividend(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// Small fully-associative result cache keyed by {sign, op1, op2}; lowest matching
// index wins, replacement is a round-robin pointer advanced on every write.
module div_result_cache #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W:0]     lookup_key_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     hit_quo_o,
  output logic [DATA_W-1:0]     hit_rem_o,
  input  logic                  wr_en_i,
  input  logic [2*DATA_W:0]     wr_key_i,
  input  logic [DATA_W-1:0]     wr_quo_i,
  input  logic [DATA_W-1:0]     wr_rem_i
);
  localparam int KEY_W = 2 * DATA_W + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid_q;
  logic [KEY_W-1:0]  key_q [DEPTH];
  logic [DATA_W-1:0] quo_q [DEPTH];
  logic [DATA_W-1:0] rem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [DEPTH-1:0]  match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_q[gi] & (key_q[gi] == lookup_key_i);
    end
  endgenerate

  // Scan downwards so the lowest matching index is the one that sticks.
  always_comb begin
    hit_o     = 1'b0;
    hit_quo_o = '0;
    hit_rem_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o     = 1'b1;
        hit_quo_o = quo_q[i];
        hit_rem_o = rem_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (wr_en_i) begin
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      key_q[ptr_q] <= wr_key_i;
      quo_q[ptr_q] <= wr_quo_i;
      rem_q[ptr_q] <= wr_rem_i;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer between the ALU and the SRT divider core: resolves divide-by-zero,
// signed overflow and cache hits locally, otherwise runs the core.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int CACHE_DEPTH = 8,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_sign,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_quo,
  output logic [DATA_W-1:0] resp_rem,
  output logic              core_start,
  output logic              core_abort,
  output logic              core_sign,
  output logic [DATA_W-1:0] core_op1,
  output logic [DATA_W-1:0] core_op2,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_quo,
  input  logic [DATA_W-1:0] core_rem
);
  localparam logic [DATA_W-1:0] ZERO_QUO = DIV_ZERO_QUO[DATA_W-1:0];
  localparam logic [DATA_W-1:0] OVF_OP1  = DATA_W'(ovf_dividend(DATA_W));

  state_e            state_q;
  logic              sign_q;
  logic [DATA_W-1:0] op1_q, op2_q, quo_q, rem_q;
  logic              start_q, abort_q;

  logic              accept, div_zero, sgn_ovf, hit, wr_en;
  logic [DATA_W-1:0] hit_quo, hit_rem;

  assign req_ready  = (state_q == ST_IDLE) & ~flush;
  assign accept     = req_valid & req_ready;
  assign div_zero   = (req_op2 == '0);
  assign sgn_ovf    = req_sign & (req_op1 == OVF_OP1) & (req_op2 == ZERO_QUO);
  assign wr_en      = (state_q == ST_BUSY) & core_done & ~flush;

  assign resp_valid = (state_q == ST_DONE);
  assign resp_quo   = quo_q;
  assign resp_rem   = rem_q;
  assign core_start = start_q;
  assign core_abort = abort_q;
  assign core_sign  = sign_q;
  assign core_op1   = op1_q;
  assign core_op2   = op2_q;

  // The decision is made in the accept cycle so local results arrive one cycle later.
  div_result_cache #(
    .DEPTH  (CACHE_DEPTH),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk          (clk),
    .rst          (rst),
    .lookup_key_i ({req_sign, req_op1, req_op2}),
    .hit_o        (hit),
    .hit_quo_o    (hit_quo),
    .hit_rem_o    (hit_rem),
    .wr_en_i      (wr_en),
    .wr_key_i     ({sign_q, op1_q, op2_q}),
    .wr_quo_i     (core_quo),
    .wr_rem_i     (core_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        abort_q <= (state_q == ST_BUSY);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              sign_q <= req_sign;
              op1_q  <= req_op1;
              op2_q  <= req_op2;
              if (div_zero) begin
                quo_q   <= ZERO_QUO;
                rem_q   <= req_op1;
                state_q <= ST_DONE;
              end else if (sgn_ovf) begin
                quo_q   <= OVF_OP1;
                rem_q   <= '0;
                state_q <= ST_DONE;
              end else if (hit) begin
                quo_q   <= hit_quo;
                rem_q   <= hit_rem;
                state_q <= ST_DONE;
              end else begin
                start_q <= 1'b1;
                state_q <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            if (core_done) begin
              quo_q   <= core_quo;
              rem_q   <= core_rem;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (resp_ready) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider core and a
// queue of expected responses.
module tb_div_issue_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, req_valid, req_ready, req_sign;
  logic [W-1:0] req_op1, req_op2;
  logic         resp_valid, resp_ready;
  logic [W-1:0] resp_quo, resp_rem;
  logic         core_start, core_abort, core_sign;
  logic [W-1:0] core_op1, core_op2;
  logic         core_done;
  logic [W-1:0] core_quo, core_rem;

  always #5 clk = ~clk;

  div_issue_ctrl #(.CACHE_DEPTH(8), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sign   (req_sign),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_quo   (resp_quo),
    .resp_rem   (resp_rem),
    .core_start (core_start),
    .core_abort (core_abort),
    .core_sign  (core_sign),
    .core_op1   (core_op1),
    .core_op2   (core_op2),
    .core_done  (core_done),
    .core_quo   (core_quo),
    .core_rem   (core_rem)
  );

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
  } res_t;

  res_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           n_start = 0;
  int           n_abort = 0;
  int           core_lat = 3;
  int           core_cnt;
  logic [W-1:0] m_q, m_r;

  always @(posedge clk) begin
    if (core_start) n_start <= n_start + 1;
    if (core_abort) n_abort <= n_abort + 1;
  end

  // Behavioural divider core: done arrives a fixed number of cycles after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_quo  <= '0;
      core_rem  <= '0;
      m_q       <= '0;
      m_r       <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_abort) begin
        core_cnt <= 0;
      end else if (core_start) begin
        core_cnt <= core_lat;
        if (core_sign) begin
          m_q <= $signed(core_op1) / $signed(core_op2);
          m_r <= $signed(core_op1) % $signed(core_op2);
        end else begin
          m_q <= core_op1 / core_op2;
          m_r <= core_op1 % core_op2;
        end
      end else if (core_cnt == 1) begin
        core_done <= 1'b1;
        core_quo  <= m_q;
        core_rem  <= m_r;
        core_cnt  <= 0;
      end else if (core_cnt > 1) begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int i;
    req_valid = 1'b1;
    req_sign  = s;
    req_op1   = a;
    req_op2   = b;
    i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag, output int lat);
    res_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 100);
    if (!resp_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_quo"}, 64'(resp_quo), 64'(e.quo));
      check({tag, "_rem"}, 64'(resp_rem), 64'(e.rem));
    end else begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end
    $display("resp %s quo=%h rem=%h lat=%0d", tag, resp_quo, resp_rem, lat);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  // One full transaction; a miss responds core_lat+3 negedges after the accept edge.
  task automatic op(input string tag, input logic s, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] qe,
                    input logic [W-1:0] re, input bit miss);
    int lat, s0;
    exp_q.push_back(res_t'{quo: qe, rem: re});
    s0 = n_start;
    send(s, a, b);
    get_resp(tag, lat);
    check({tag, "_starts"}, 64'(n_start - s0), miss ? 64'd1 : 64'd0);
    check({tag, "_lat"}, 64'(lat), miss ? 64'(core_lat + 3) : 64'd1);
  endtask

  initial begin
    int i, lat, a0, s0;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_sign = 1'b0;
    req_op1 = '0; req_op2 = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_abort", 64'(core_abort), 64'd0);
    check("rst_resp_quo", 64'(resp_quo), 64'd0);
    check("rst_core_op1", 64'(core_op1), 64'd0);

    // Unsigned miss with back-pressure on the response.
    exp_q.push_back(res_t'{quo: 32'd14, rem: 32'd2});
    s0 = n_start;
    send(1'b0, 32'd100, 32'd7);
    i = 0;
    while (!resp_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_quo", 64'(resp_quo), 64'd14);
    end
    get_resp("miss_100_7", lat);
    check("miss_100_7_starts", 64'(n_start - s0), 64'd1);

    op("hit_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    op("div_zero", 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b0);
    op("sgn_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b1);
    op("s_m7_2_hit", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    // Flush three cycles into BUSY.
    core_lat = 10;
    a0 = n_abort;
    send(1'b0, 32'd55, 32'd5);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_abort_pulse", 64'(core_abort), 64'd1);
    check("flush_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("flush_abort_once", 64'(n_abort - a0), 64'd1);
    repeat (12) @(negedge clk);
    check("flush_no_resp", 64'(resp_valid), 64'd0);
    core_lat = 3;
    op("flush_retry", 1'b0, 32'd55, 32'd5, 32'd11, 32'd0, 1'b1);

    // Flush in the same cycle as core_done.
    send(1'b0, 32'd60, 32'd4);
    i = 0;
    while (!core_done && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("fd_done_seen", 64'(core_done), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fd_no_resp", 64'(resp_valid), 64'd0);
    check("fd_idle", 64'(req_ready), 64'd1);
    op("fd_retry", 1'b0, 32'd60, 32'd4, 32'd15, 32'd0, 1'b1);

    // Clear the cache, then overflow it by one entry.
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      op($sformatf("fill%0d", k), 1'b0, 32'(1000 + k), 32'(k + 2),
         32'((1000 + k) / (k + 2)), 32'((1000 + k) % (k + 2)), 1'b1);
    end
    op("evict_pair2_hit", 1'b0, 32'd1002, 32'd4, 32'd250, 32'd2, 1'b0);
    op("evict_pair9_hit", 1'b0, 32'd1009, 32'd11, 32'd91, 32'd8, 1'b0);
    op("evict_pair1_miss", 1'b0, 32'd1001, 32'd3, 32'd333, 32'd2, 1'b1);

    // Asynchronous reset in the middle of a core run.
    core_lat = 10;
    a0 = n_abort;
    send(1'b0, 32'd77, 32'd3);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 64'(req_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_core_op1", 64'(core_op1), 64'd0);
    check("arst_core_sign", 64'(core_sign), 64'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_abort", 64'(n_abort - a0), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
